// File: rtl/martian_calendar_ctrl_if.sv
// martian_calendar_ctrl_if: control/date bus of the Martian calendar sequencer (wday only with MARTIAN_CAL_WEEKDAY_EN)
interface martian_calendar_ctrl_if #(parameter int YEAR_W = 16);
  logic              run;
  logic              tick;
  logic              load;
  logic [YEAR_W-1:0] load_year;
  logic [4:0]        load_month;
  logic [4:0]        load_sol;
  logic [YEAR_W-1:0] year;
  logic [4:0]        month;
  logic [4:0]        sol;
  logic              ly;
  logic              month_end;
  logic              year_end;
  logic              err;
  logic              load_ack;
`ifdef MARTIAN_CAL_WEEKDAY_EN
  logic [2:0]        wday;
`endif
  modport master (
    output run, tick, load, load_year, load_month, load_sol,
`ifdef MARTIAN_CAL_WEEKDAY_EN
    input  wday,
`endif
    input  year, month, sol, ly, month_end, year_end, err, load_ack
  );
  modport slave (
    input  run, tick, load, load_year, load_month, load_sol,
`ifdef MARTIAN_CAL_WEEKDAY_EN
    output wday,
`endif
    output year, month, sol, ly, month_end, year_end, err, load_ack
  );
endinterface

// File: rtl/martian_calendar_ctrl.sv
// martian_calendar_ctrl: Martian date sequencer driving martian_days; weekday counter under MARTIAN_CAL_WEEKDAY_EN
module martian_days (
  input  logic [4:0] M,
  input  logic       LY,
  output logic       D27,
  output logic       D28
);
  logic short_m;
  // every sixth month is 27 sols, except the last month of a leap year
  always_comb begin
    short_m = (M == 5'd5) || (M == 5'd11) || (M == 5'd17) || (M == 5'd23 && !LY);
    D28     = (M <= 5'd23) && !short_m;
    D27     = (M <= 5'd23) && short_m;
  end
endmodule

module martian_calendar_ctrl #(
  parameter int YEAR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  martian_calendar_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t            state_q, state_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [4:0]        month_q, month_d, sol_q, sol_d;
  logic              me_q, me_d, ye_q, ye_d, ack_q, ack_d;
  logic              c27, c28, l27, l28, ld_ok, last;
  logic [4:0]        cur_len, ld_len;
`ifdef MARTIAN_CAL_WEEKDAY_EN
  logic [2:0]        wday_q, wday_d;
`endif

  function automatic logic leap(input logic [YEAR_W-1:0] y);
    return y[0] | (y % YEAR_W'(10) == '0);
  endfunction

  martian_days u_cur (.M(month_q),        .LY(leap(year_q)),        .D27(c27), .D28(c28));
  martian_days u_ld  (.M(bus.load_month), .LY(leap(bus.load_year)), .D27(l27), .D28(l28));

  assign cur_len = c28 ? 5'd28 : 5'd27;
  assign ld_len  = l28 ? 5'd28 : 5'd27;
  assign ld_ok   = (bus.load_month <= 5'd23) && (bus.load_sol != 5'd0) && (l27 != l28) && (bus.load_sol <= ld_len);
  assign last    = sol_q == cur_len;

  // next date and state: load beats the consistency check, which beats run/tick
  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    sol_d   = sol_q;
    me_d    = 1'b0;
    ye_d    = 1'b0;
    ack_d   = bus.load;
`ifdef MARTIAN_CAL_WEEKDAY_EN
    wday_d  = wday_q;
`endif
    if (bus.load) begin
      if (ld_ok) begin
        year_d  = bus.load_year;
        month_d = bus.load_month;
        sol_d   = bus.load_sol;
        state_d = bus.run ? RUN : IDLE;
`ifdef MARTIAN_CAL_WEEKDAY_EN
        wday_d  = 3'd0;
`endif
      end else begin
        state_d = ERR;
      end
    end else if (state_q == IDLE) begin
      state_d = bus.run ? RUN : IDLE;
    end else if (state_q == RUN) begin
      if (c27 == c28) begin
        state_d = ERR;
      end else if (!bus.run) begin
        state_d = IDLE;
      end else if (bus.tick) begin
        sol_d   = last ? 5'd1 : sol_q + 5'd1;
        me_d    = last;
        ye_d    = last && month_q == 5'd23;
        month_d = last ? (month_q == 5'd23 ? 5'd0 : month_q + 5'd1) : month_q;
        year_d  = ye_d ? year_q + YEAR_W'(1) : year_q;
`ifdef MARTIAN_CAL_WEEKDAY_EN
        wday_d  = wday_q == 3'd6 ? 3'd0 : wday_q + 3'd1;
`endif
      end
    end
  end

  // state and date registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      year_q  <= '0;
      month_q <= 5'd0;
      sol_q   <= 5'd1;
      me_q    <= 1'b0;
      ye_q    <= 1'b0;
      ack_q   <= 1'b0;
`ifdef MARTIAN_CAL_WEEKDAY_EN
      wday_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      sol_q   <= sol_d;
      me_q    <= me_d;
      ye_q    <= ye_d;
      ack_q   <= ack_d;
`ifdef MARTIAN_CAL_WEEKDAY_EN
      wday_q  <= wday_d;
`endif
    end
  end

  assign bus.year      = year_q;
  assign bus.month     = month_q;
  assign bus.sol       = sol_q;
  assign bus.ly        = leap(year_q);
  assign bus.month_end = me_q;
  assign bus.year_end  = ye_q;
  assign bus.err       = state_q == ERR;
  assign bus.load_ack  = ack_q;
`ifdef MARTIAN_CAL_WEEKDAY_EN
  assign bus.wday      = wday_q;
`endif
endmodule

// File: tb/tb_martian_calendar_ctrl.sv
// tb_martian_calendar_ctrl: randomized and directed checks of martian_calendar_ctrl against a date-level model
module tb_martian_calendar_ctrl;
  localparam int YW = 16;
`ifdef MARTIAN_CAL_WEEKDAY_EN
  localparam int VW = YW + 18;
`else
  localparam int VW = YW + 15;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0, failures = 0;
  int m_year, m_month, m_sol, m_wday;
  bit m_me, m_ye, m_ack, m_err, m_run;

  always #5 clk = ~clk;

  martian_calendar_ctrl_if #(.YEAR_W(YW)) bus();
  martian_calendar_ctrl #(.YEAR_W(YW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic bit leap(int y);
    return (y % 2 == 1) || (y % 10 == 0);
  endfunction

  function automatic int mlen(int m, int y);
    return ((m + 1) % 6 == 0 && !(m == 23 && leap(y))) ? 27 : 28;
  endfunction

  function automatic logic [VW-1:0] got_v();
    return {bus.year, bus.month, bus.sol, bus.ly, bus.month_end, bus.year_end, bus.err, bus.load_ack
`ifdef MARTIAN_CAL_WEEKDAY_EN
            , bus.wday
`endif
           };
  endfunction

  function automatic logic [VW-1:0] exp_v();
    return {YW'(m_year), 5'(m_month), 5'(m_sol), leap(m_year), m_me, m_ye, m_err, m_ack
`ifdef MARTIAN_CAL_WEEKDAY_EN
            , 3'(m_wday)
`endif
           };
  endfunction

  task automatic model();
    int lm, ls, ly;
    if (rst) begin
      m_year = 0; m_month = 0; m_sol = 1; m_wday = 0;
      {m_me, m_ye, m_ack, m_err, m_run} = '0;
      return;
    end
    m_me = 0; m_ye = 0; m_ack = bus.load;
    lm = int'(bus.load_month); ls = int'(bus.load_sol); ly = int'(bus.load_year);
    if (bus.load) begin
      if (lm <= 23 && ls >= 1 && ls <= mlen(lm, ly)) begin
        m_year = ly; m_month = lm; m_sol = ls; m_err = 0; m_run = bus.run; m_wday = 0;
      end else begin
        m_err = 1; m_run = 0;
      end
    end else if (!m_err) begin
      if (!m_run) m_run = bus.run;
      else if (!bus.run) m_run = 0;
      else if (bus.tick) begin
        m_wday = (m_wday + 1) % 7;
        if (m_sol < mlen(m_month, m_year)) m_sol++;
        else begin
          m_sol = 1; m_me = 1;
          if (m_month < 23) m_month++;
          else begin
            m_month = 0; m_ye = 1; m_year = (m_year + 1) % (1 << YW);
          end
        end
      end
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int y, int m, int s);
    bus.load = 1; bus.load_year = YW'(y); bus.load_month = 5'(m); bus.load_sol = 5'(s);
    step();
    bus.load = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    checks++;
    if (got_v() !== exp_v()) begin failures++; $display("FAIL reset_model got=%h exp=%h", got_v(), exp_v()); end
    checks++;
    if ({bus.year, bus.month, bus.sol, bus.ly, bus.month_end, bus.year_end, bus.err, bus.load_ack} !== {16'd0, 5'd0, 5'd1, 1'b1, 4'b0})
      begin failures++; $display("FAIL reset_const got=%h/%0d/%0d", bus.year, bus.month, bus.sol); end
  endtask

  task automatic test_count();
    bus.run = 1;
    step();
    bus.tick = 1;
    for (int i = 1; i <= 28; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v()) begin failures++; $display("FAIL count_%0d got=%h exp=%h", i, got_v(), exp_v()); end
      if (i == 27) begin
        checks++;
        if ({bus.month, bus.sol, bus.month_end} !== {5'd0, 5'd28, 1'b0}) begin failures++; $display("FAIL count_sol28 got=%0d/%0d exp=0/28", bus.month, bus.sol); end
      end
    end
    checks++;
    if ({bus.month, bus.sol, bus.month_end, bus.year_end} !== {5'd1, 5'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL count_month_end got=%0d/%0d/%b exp=1/1/1", bus.month, bus.sol, bus.month_end); end
    bus.tick = 0;
    step();
    checks++;
    if (bus.month_end !== 1'b0) begin failures++; $display("FAIL count_pulse got=%b exp=0", bus.month_end); end
  endtask

  task automatic test_leap_rollover();
    do_load(1, 23, 28);
    checks++;
    if ({bus.year, bus.month, bus.sol, bus.err, bus.load_ack} !== {16'd1, 5'd23, 5'd28, 1'b0, 1'b1}) begin failures++; $display("FAIL leap_load got=%h exp=%h", got_v(), exp_v()); end
    bus.tick = 1;
    step();
    bus.tick = 0;
    checks++;
    if ({bus.year, bus.month, bus.sol, bus.month_end, bus.year_end} !== {16'd2, 5'd0, 5'd1, 1'b1, 1'b1}) begin failures++; $display("FAIL year_roll got=%h exp=%h", got_v(), exp_v()); end
    do_load(2, 23, 28);
    checks++;
    if ({bus.err, bus.load_ack, bus.year, bus.month, bus.sol} !== {1'b1, 1'b1, 16'd2, 5'd0, 5'd1}) begin failures++; $display("FAIL nonleap_reject got=%h exp=%h", got_v(), exp_v()); end
  endtask

  task automatic test_err_freeze();
    bus.tick = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v()) begin failures++; $display("FAIL err_freeze_%0d got=%h exp=%h", i, got_v(), exp_v()); end
    end
    bus.tick = 0;
    do_load(10, 5, 27);
    checks++;
    if ({bus.err, bus.ly, bus.year, bus.month, bus.sol} !== {1'b0, 1'b1, 16'd10, 5'd5, 5'd27}) begin failures++; $display("FAIL err_recover got=%h exp=%h", got_v(), exp_v()); end
    do_load(4, 5, 28);
    checks++;
    if ({bus.err, bus.year} !== {1'b1, 16'd10}) begin failures++; $display("FAIL short_month_reject got=%h exp=%h", got_v(), exp_v()); end
    do_load(4, 3, 0);
    checks++;
    if (got_v() !== exp_v()) begin failures++; $display("FAIL sol0_reject got=%h exp=%h", got_v(), exp_v()); end
    do_load(4, 24, 1);
    checks++;
    if (got_v() !== exp_v()) begin failures++; $display("FAIL month24_reject got=%h exp=%h", got_v(), exp_v()); end
  endtask

  task automatic test_load_tick();
    bus.tick = 1;
    do_load(7, 3, 12);
    checks++;
    if ({bus.year, bus.month, bus.sol, bus.err} !== {16'd7, 5'd3, 5'd12, 1'b0}) begin failures++; $display("FAIL load_tick got=%h exp=%h", got_v(), exp_v()); end
    bus.run = 0;
    step();
    step();
    bus.tick = 0;
    checks++;
    if ({bus.year, bus.month, bus.sol} !== {16'd7, 5'd3, 5'd12}) begin failures++; $display("FAIL stop_tick got=%h exp=%h", got_v(), exp_v()); end
  endtask

  task automatic test_wrap();
    bus.run = 1;
    step();
    do_load(65535, 23, 28);
    bus.tick = 1;
    step();
    checks++;
    if ({bus.year, bus.month, bus.sol, bus.year_end} !== {16'd0, 5'd0, 5'd1, 1'b1}) begin failures++; $display("FAIL year_wrap got=%h exp=%h", got_v(), exp_v()); end
    step();
    step();
    rst = 1;
    bus.load = 1; bus.load_year = 16'd9; bus.load_month = 5'd2; bus.load_sol = 5'd2;
    step();
    rst = 0; bus.load = 0; bus.tick = 0;
    checks++;
    if (got_v() !== {16'd0, 5'd0, 5'd1, 1'b1, 4'b0
`ifdef MARTIAN_CAL_WEEKDAY_EN
        , 3'd0
`endif
       }) begin failures++; $display("FAIL rst_mid_run got=%h exp=%h", got_v(), exp_v()); end
  endtask

  task automatic test_random();
    int m;
    for (int i = 0; i < 800; i++) begin
      bus.run  = $urandom_range(0, 9) != 0;
      bus.tick = $urandom_range(0, 1) == 1;
      bus.load = $urandom_range(0, 24) == 0;
      rst      = $urandom_range(0, 149) == 0;
      bus.load_year = YW'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        m = $urandom_range(0, 23);
        bus.load_month = 5'(m);
        bus.load_sol = 5'($urandom_range(mlen(m, int'(bus.load_year)) - 1, mlen(m, int'(bus.load_year))));
      end else begin
        bus.load_month = 5'($urandom_range(0, 31));
        bus.load_sol = 5'($urandom_range(0, 31));
      end
      step();
      checks++;
      if (got_v() !== exp_v()) begin failures++; $display("FAIL random_%0d got=%h exp=%h", i, got_v(), exp_v()); end
    end
    rst = 0; bus.load = 0; bus.tick = 0;
  endtask

`ifdef MARTIAN_CAL_WEEKDAY_EN
  task automatic test_weekday();
    rst = 1;
    step();
    rst = 0; bus.run = 1;
    step();
    bus.tick = 1;
    repeat (10) step();
    bus.tick = 0;
    checks++;
    if (bus.wday !== 3'd3) begin failures++; $display("FAIL wday_10 got=%0d exp=3", bus.wday); end
    do_load(5, 1, 1);
    checks++;
    if (bus.wday !== 3'd0) begin failures++; $display("FAIL wday_load got=%0d exp=0", bus.wday); end
  endtask
`endif

  initial begin
    rst = 1;
    bus.run = 0; bus.tick = 0; bus.load = 0;
    bus.load_year = '0; bus.load_month = '0; bus.load_sol = '0;
    test_reset();
    test_count();
    test_leap_rollover();
    test_err_freeze();
    test_load_tick();
    test_wrap();
    test_random();
`ifdef MARTIAN_CAL_WEEKDAY_EN
    test_weekday();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
